mem_port_arbiter: RTL and testbench

Arbitrates a single-port synchronous RAM between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the pipelined CPU. It runs one access at a time through a fixed-sequence FSM and returns read data with a one-cycle acknowledge pulse. It also drives the per-requester stall signals that freeze the pipeline stages while they wait. It sits between `fetch_decode`/`mem_wb` and the shared memory macro.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter between fetch and data requesters
// Optional fetch-fairness streak counter enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_fetch,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    if (MEM_LAT < 1 || MAX_STREAK < 1) begin : g_bad_param
        $error("mem_port_arbiter: MEM_LAT and MAX_STREAK must be >= 1");
    end

    logic [1:0]        state;
    logic              owner_d;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              any_req;
    logic              grant_d;

    assign any_req = if_req | d_req;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak;
    logic                force_fetch;

    // Only contended data grants build the streak; fetch wins once it saturates.
    assign force_fetch = if_req & d_req & (streak == STREAK_MAX);
    assign grant_d     = d_req & ~force_fetch;

    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (state == S_IDLE && any_req) begin
            if (grant_d && if_req) begin
                if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end else begin
                streak <= '0;
            end
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            owner_d    <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner_d  <= grant_d;
                        lat_we   <= grant_d & d_we;
                        lat_addr <= grant_d ? d_addr : if_addr;
                        if (grant_d) begin
                            lat_wdata <= d_wdata;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= CNT_LOAD;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        if (!lat_we) begin
                            if (owner_d) begin
                                d_rdata_q <= mem_rdata;
                            end else begin
                                if_rdata_q <= mem_rdata;
                            end
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_en      = (state == S_ISSUE);
    assign mem_we      = mem_en & lat_we;
    assign mem_addr    = lat_addr;
    assign mem_wdata   = lat_wdata;
    assign if_ack      = (state == S_RESP) & ~owner_d;
    assign d_ack       = (state == S_RESP) & owner_d;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign stall_fetch = if_req & ~if_ack;
    assign stall_mem   = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized transaction-level check of mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int MAXS = 4;
    localparam int PER  = LAT + 3;
`ifdef MEM_ARB_FAIRNESS_EN
    localparam int EXP_STARVE_IF = 1;
    localparam int EXP_STARVE_D  = 4;
`else
    localparam int EXP_STARVE_IF = 0;
    localparam int EXP_STARVE_D  = 5;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          stall_fetch, stall_mem;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_STREAK(MAXS)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .stall_fetch(stall_fetch), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 3) ? 32'hDEADBEEF : ((32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000);
    endfunction

    // Memory macro: refilled during reset, read data appears LAT cycles after mem_en.
    logic [DW-1:0] ram  [32];
    logic [DW-1:0] pipe [LAT];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) ram[i] <= init_val(i);
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 32'hBAD00000;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester stimulus state
    int            p_if = 0, p_d = 0;
    bit            if_pend = 0, d_pend = 0;
    bit            saw_if_ack = 0, saw_d_ack = 0;
    logic [AW-1:0] q_if_addr = '0, q_d_addr = '0;
    logic          q_d_we = 1'b0;
    logic [DW-1:0] q_d_wdata = '0;
    int            n_if_ack = 0, n_d_ack = 0;
    int            if_ack_cyc = 0, d_ack_cyc = 0;

    // Reference model: one transaction at a time, scheduled by cycle number
    int            cyc = 0;
    bit            busy = 0;
    bit            just_rst = 1;
    bit            m_own_d = 0, m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rd = '0;
    int            issue_cyc = 0, ack_cyc = 0;
    logic [DW-1:0] shadow [32];
    logic [DW-1:0] e_if_rd = '0, e_d_rd = '0;
    logic [AW-1:0] e_addr = '0;
`ifdef MEM_ARB_FAIRNESS_EN
    int            streak = 0;
`endif

    task automatic req_if(input logic [AW-1:0] a);
        if_pend = 1; q_if_addr = a;
    endtask

    task automatic req_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        d_pend = 1; q_d_we = we; q_d_addr = a; q_d_wdata = wd;
    endtask

    task automatic tick(input bit rst);
        bit e_ack, e_iss, take_d;
        @(posedge clk);
        #1;
        cyc++;
        reset = rst;
        if (rst) begin
            if_pend = 0; d_pend = 0;
        end else begin
            if (if_pend && saw_if_ack) if_pend = 0;
            if (d_pend && saw_d_ack) d_pend = 0;
            if (!if_pend && $urandom_range(99) < p_if) req_if(AW'($urandom_range(31)));
            if (!d_pend && $urandom_range(99) < p_d)
                req_d(1'($urandom_range(1)), AW'($urandom_range(31)), $urandom);
        end
        if_req = if_pend; if_addr = q_if_addr;
        d_req = d_pend; d_we = q_d_we; d_addr = q_d_addr; d_wdata = q_d_wdata;
        #1;
        e_ack = busy && (cyc == ack_cyc);
        e_iss = busy && (cyc == issue_cyc);
        if (e_ack && !m_we) begin
            if (m_own_d) e_d_rd = m_rd; else e_if_rd = m_rd;
        end
        check("if_ack", if_ack, e_ack && !m_own_d);
        check("d_ack", d_ack, e_ack && m_own_d);
        check("if_rdata", if_rdata, e_if_rd);
        check("d_rdata", d_rdata, e_d_rd);
        check("mem_en", mem_en, e_iss);
        check("mem_we", mem_we, e_iss && m_we);
        check("mem_addr", mem_addr, e_addr);
        if (e_iss && m_we) check("mem_wdata", mem_wdata, m_wdata);
        if (just_rst) check("mem_wdata_rst", mem_wdata, 0);
        check("stall_fetch", stall_fetch, if_req && !(e_ack && !m_own_d));
        check("stall_mem", stall_mem, d_req && !(e_ack && m_own_d));
        if (if_ack) begin n_if_ack++; if_ack_cyc = cyc; end
        if (d_ack) begin n_d_ack++; d_ack_cyc = cyc; end
        saw_if_ack = if_ack; saw_d_ack = d_ack;
        just_rst = rst;
        if (rst) begin
            busy = 0; e_if_rd = '0; e_d_rd = '0; e_addr = '0;
            for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
`ifdef MEM_ARB_FAIRNESS_EN
            streak = 0;
`endif
        end else if (busy && cyc == ack_cyc) begin
            busy = 0;
        end else if (!busy && (if_req || d_req)) begin
`ifdef MEM_ARB_FAIRNESS_EN
            take_d = d_req && !(if_req && streak == MAXS);
            if (take_d && if_req) streak = (streak < MAXS) ? streak + 1 : MAXS;
            else streak = 0;
`else
            take_d = d_req;
`endif
            m_own_d = take_d;
            m_we    = take_d && d_we;
            m_addr  = take_d ? d_addr : if_addr;
            m_wdata = d_wdata;
            m_rd    = shadow[m_addr];
            if (m_we) shadow[m_addr] = m_wdata;
            issue_cyc = cyc + 1;
            ack_cyc   = cyc + 2 + LAT;
            busy      = 1;
            e_addr    = m_addr;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (if_pend || d_pend || busy); i++) tick(0);
        check("drain_done", {if_pend, d_pend, busy}, 0);
    endtask

    int start, ack_base, if_base, d_base;

    initial begin
        for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
        repeat (3) tick(1);

        // fetch read from address 3
        req_if(5'd3);
        start = cyc + 1;
        repeat (2 * PER) tick(0);
        check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        check("t1_ack_lat", if_ack_cyc - start, 2 + LAT);

        // store then fetch read-back of the same word
        ack_base = n_d_ack;
        req_d(1'b1, 5'd7, 32'h12345678);
        repeat (2 * PER) tick(0);
        check("t2_store_ack", n_d_ack - ack_base, 1);
        check("t2_d_rdata_kept", d_rdata, 0);
        req_if(5'd7);
        repeat (2 * PER) tick(0);
        check("t2_readback", if_rdata, 32'h12345678);

        // simultaneous requests: data first, fetch one access later
        req_if(5'd9);
        req_d(1'b0, 5'd3, 32'h0);
        start = cyc + 1;
        repeat (3 * PER) tick(0);
        check("t3_d_first", d_ack_cyc - start, 2 + LAT);
        check("t3_if_second", if_ack_cyc - start, PER + 2 + LAT);
        check("t3_d_rdata", d_rdata, 32'hDEADBEEF);

        // saturated contention from a clean reset
        tick(1);
        p_if = 100; p_d = 100;
        if_base = n_if_ack; d_base = n_d_ack;
        repeat (5 * PER) tick(0);
        check("t4_if_acks", n_if_ack - if_base, EXP_STARVE_IF);
        check("t4_d_acks", n_d_ack - d_base, EXP_STARVE_D);
        p_if = 0; p_d = 0;
        drain();

        // reset during WAIT drops the access
        d_base = n_d_ack;
        req_d(1'b0, 5'd5, 32'h0);
        repeat (3) tick(0);
        tick(1);
        repeat (PER) tick(0);
        check("t5_no_ack", n_d_ack - d_base, 0);
        req_if(5'd3);
        repeat (2 * PER) tick(0);
        check("t5_fresh", if_rdata, 32'hDEADBEEF);

        // randomized traffic
        p_if = 45; p_d = 45;
        repeat (3000) tick(0);
        p_if = 0; p_d = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
